// File: rtl/result_bcd_display.sv
`default_nettype none
// ============================================================================
// Module   : result_bcd_display
// Purpose  : Display stage of the calculator datapath. Captures a signed
//            result (or an error flag) from the processing element. It
//            converts the magnitude to five BCD digits with a sequential
//            double-dabble, one bit per cycle. It then drives five registered
//            active-low 7-segment digits, a sign LED and an ERROR LED.
// Options  : LEADING_ZERO_BLANK_EN - blank leading zero digits above the
//            highest nonzero digit (ONES always shows a digit).
// Revision : 1.0 - initial release
// ============================================================================
module result_bcd_display #(
  parameter int DATA_W      = 16,  // two's complement result width, <= 16
  parameter int SHIFT_CNT_W = 5    // iteration counter width, must hold DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] result,
  input  logic              error_in,
  output logic              busy,
  output logic              ready,
  output logic [6:0]        ONES,
  output logic [6:0]        TENS,
  output logic [6:0]        HUNDREDS,
  output logic [6:0]        THOUSAND,
  output logic [6:0]        TEN_THOUSAND,
  output logic              sign,
  output logic              ERROR
);

  localparam int c_NDIG  = 5;
  localparam int c_BCD_W = 4 * c_NDIG;

  localparam logic [6:0] c_SEG_BLANK = 7'h7F;
  localparam logic [6:0] c_SEG_DASH  = 7'h3F;

  // The counter value seen on the final shift cycle
  localparam logic [SHIFT_CNT_W-1:0] c_LAST_SHIFT = SHIFT_CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CONVERT = 2'd1,
    S_LOAD    = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // State and registers
  // --------------------------------------------------------------------------
  state_t                 r_state;
  logic [c_BCD_W-1:0]     r_bcd;
  logic [DATA_W-1:0]      r_mag;
  logic                   r_neg;
  logic                   r_err;
  logic [SHIFT_CNT_W-1:0] r_cnt;

  logic                   r_busy;
  logic                   r_ready;
  logic                   r_sign;
  logic                   r_error;
  logic [6:0]             r_ones;
  logic [6:0]             r_tens;
  logic [6:0]             r_hundreds;
  logic [6:0]             r_thousand;
  logic [6:0]             r_ten_thousand;

  // --------------------------------------------------------------------------
  // Combinational datapath
  // --------------------------------------------------------------------------
  logic [DATA_W-1:0]      w_mag_in;
  logic [c_BCD_W-1:0]     w_bcd_adj;
  logic [c_NDIG-1:0]      w_lead_zero;
  logic [6:0]             w_seg [c_NDIG];

  // Most negative input negates to itself as a bit pattern, which is
  // the correct unsigned magnitude, so no overflow handling is needed
  assign w_mag_in = result[DATA_W-1] ? (~result + DATA_W'(1)) : result;

  // Decimal digit to active-low {g,f,e,d,c,b,a}; codes 10..15 never occur
  function automatic logic [6:0] f_seg(input logic [3:0] i_digit);
    logic [6:0] v_seg;
    case (i_digit)
      4'd0:    v_seg = 7'h40;
      4'd1:    v_seg = 7'h79;
      4'd2:    v_seg = 7'h24;
      4'd3:    v_seg = 7'h30;
      4'd4:    v_seg = 7'h19;
      4'd5:    v_seg = 7'h12;
      4'd6:    v_seg = 7'h02;
      4'd7:    v_seg = 7'h78;
      4'd8:    v_seg = 7'h00;
      4'd9:    v_seg = 7'h10;
      default: v_seg = c_SEG_BLANK;
    endcase
    return v_seg;
  endfunction

  // Add-3 correction on each nibble >= 5 before every shift
  genvar gi;
  generate
    for (gi = 0; gi < c_NDIG; gi++) begin : g_adj
      assign w_bcd_adj[4*gi +: 4] = (r_bcd[4*gi +: 4] >= 4'd5)
                                  ? (r_bcd[4*gi +: 4] + 4'd3)
                                  : r_bcd[4*gi +: 4];
    end
  endgenerate

`ifdef LEADING_ZERO_BLANK_EN
  // Flag digits that are zero with every higher digit also zero; ONES never
  always_comb begin
    logic v_run;
    w_lead_zero = '0;
    v_run       = 1'b1;
    for (int i = c_NDIG - 1; i >= 1; i--) begin
      v_run          = v_run & (r_bcd[4*i +: 4] == 4'd0);
      w_lead_zero[i] = v_run;
    end
  end
`else
  // All five digits are always shown
  assign w_lead_zero = '0;
`endif

  // Segment pattern per digit, blanked where it is a leading zero
  generate
    for (gi = 0; gi < c_NDIG; gi++) begin : g_digit
      assign w_seg[gi] = w_lead_zero[gi] ? c_SEG_BLANK : f_seg(r_bcd[4*gi +: 4]);
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Control FSM with registered display outputs
  // --------------------------------------------------------------------------
  // IDLE captures, CONVERT shifts one bit per cycle, LOAD publishes the result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_bcd          <= '0;
      r_mag          <= '0;
      r_neg          <= 1'b0;
      r_err          <= 1'b0;
      r_cnt          <= '0;
      r_busy         <= 1'b0;
      r_ready        <= 1'b0;
      r_sign         <= 1'b0;
      r_error        <= 1'b0;
      r_ones         <= c_SEG_BLANK;
      r_tens         <= c_SEG_BLANK;
      r_hundreds     <= c_SEG_BLANK;
      r_thousand     <= c_SEG_BLANK;
      r_ten_thousand <= c_SEG_BLANK;
    end else begin
      r_ready <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_mag   <= w_mag_in;
            r_neg   <= result[DATA_W-1];
            r_err   <= error_in;
            r_bcd   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            // An error has nothing to convert, so publish it right away
            r_state <= error_in ? S_LOAD : S_CONVERT;
          end
        end

        S_CONVERT: begin
          // Top bit of the corrected BCD is always zero for a 16-bit input
          {r_bcd, r_mag} <= {w_bcd_adj[c_BCD_W-2:0], r_mag, 1'b0};
          r_cnt          <= r_cnt + 1'b1;
          if (r_cnt == c_LAST_SHIFT) begin
            r_state <= S_LOAD;
          end
        end

        S_LOAD: begin
          if (r_err) begin
            r_ones         <= c_SEG_DASH;
            r_tens         <= c_SEG_DASH;
            r_hundreds     <= c_SEG_DASH;
            r_thousand     <= c_SEG_DASH;
            r_ten_thousand <= c_SEG_DASH;
          end else begin
            r_ones         <= w_seg[0];
            r_tens         <= w_seg[1];
            r_hundreds     <= w_seg[2];
            r_thousand     <= w_seg[3];
            r_ten_thousand <= w_seg[4];
          end
          // Zero is never negative, so the sign bit alone is sufficient
          r_sign  <= r_neg & ~r_err;
          r_error <= r_err;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy         = r_busy;
  assign ready        = r_ready;
  assign sign         = r_sign;
  assign ERROR        = r_error;
  assign ONES         = r_ones;
  assign TENS         = r_tens;
  assign HUNDREDS     = r_hundreds;
  assign THOUSAND     = r_thousand;
  assign TEN_THOUSAND = r_ten_thousand;

endmodule
`default_nettype wire

// File: tb/tb_result_bcd_display.sv
`default_nettype none
// ============================================================================
// Module   : tb_result_bcd_display
// Purpose  : Scoreboard bench for result_bcd_display. Directed results are
//            issued; each accepted request pushes its expected display and
//            due cycle, and a monitor pops on every ready pulse.
// Revision : 1.0 - initial release
// ============================================================================
module tb_result_bcd_display;

  localparam int DATA_W = 16;

  logic              clk;
  logic              rst;
  logic              start;
  logic [DATA_W-1:0] result;
  logic              error_in;
  logic              busy;
  logic              ready;
  logic [6:0]        ONES, TENS, HUNDREDS, THOUSAND, TEN_THOUSAND;
  logic              sign;
  logic              ERROR;

  result_bcd_display #(.DATA_W(DATA_W), .SHIFT_CNT_W(5)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .result       (result),
    .error_in     (error_in),
    .busy         (busy),
    .ready        (ready),
    .ONES         (ONES),
    .TENS         (TENS),
    .HUNDREDS     (HUNDREDS),
    .THOUSAND     (THOUSAND),
    .TEN_THOUSAND (TEN_THOUSAND),
    .sign         (sign),
    .ERROR        (ERROR)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [34:0] segs;   // {TEN_THOUSAND, THOUSAND, HUNDREDS, TENS, ONES}
    logic        sgn;
    logic        er;
    logic [31:0] due;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [34:0] last_shown;

  localparam logic [34:0] BLANK5 = {5{7'h7F}};
  localparam logic [34:0] DASH5  = {5{7'h3F}};

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
      4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
      8: return 7'h00;  9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  // Hand-supplied decimal digits, most significant first
  function automatic logic [34:0] segs5(input int d4, input int d3, input int d2,
                                        input int d1, input int d0);
    int          d [5];
    logic [34:0] s;
    bit          lead;
    d[4] = d4; d[3] = d3; d[2] = d2; d[1] = d1; d[0] = d0;
    lead = 1'b1;
    s    = '0;
    for (int i = 4; i >= 0; i--) begin
      lead = lead && (d[i] == 0) && (i != 0);
`ifdef LEADING_ZERO_BLANK_EN
      s[7*i +: 7] = lead ? 7'h7F : seg_of(d[i]);
`else
      s[7*i +: 7] = seg_of(d[i]);
`endif
    end
    return s;
  endfunction

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  function automatic logic [34:0] shown();
    return {TEN_THOUSAND, THOUSAND, HUNDREDS, TENS, ONES};
  endfunction

  // Drive one start pulse sampled at the next rising edge; returns that cycle
  task automatic pulse(input logic [DATA_W-1:0] v, input logic e, output int unsigned acc);
    @(negedge clk);
    start    = 1'b1;
    result   = v;
    error_in = e;
    @(posedge clk);
    #1;
    acc      = cyc;
    start    = 1'b0;
    error_in = 1'b0;
  endtask

  // Request expected to be accepted: push its display and due cycle
  task automatic issue(input logic [DATA_W-1:0] v, input logic e,
                       input logic [34:0] segs, input logic sgn);
    int unsigned acc;
    exp_t        x;
    pulse(v, e, acc);
    check("busy_after_accept", 64'(busy), 64'(1'b1));
    x.segs = segs;
    x.sgn  = sgn;
    x.er   = e;
    x.due  = acc + (e ? 32'd1 : 32'd17);
    sb.push_back(x);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || busy) && n < 100) begin
      @(posedge clk);
      n++;
    end
    repeat (2) @(posedge clk);
    check("drain_timeout", 64'(n >= 100), 64'(0));
  endtask

  // Monitor: every ready pulse must match the oldest expected entry
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (ready === 1'b1) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_ready: got ready=1 expected no pulse (cycle %0d)", cyc);
        end else begin
          e = sb.pop_front();
          check("digits",  64'(shown()), 64'(e.segs));
          check("sign",    64'(sign),    64'(e.sgn));
          check("error",   64'(ERROR),   64'(e.er));
          check("latency", 64'(cyc),     64'(e.due));
          check("busy_at_ready", 64'(busy), 64'(1'b0));
          last_shown = e.segs;
        end
      end
    end
  end

  initial begin
    int unsigned acc;
    rst        = 1'b1;
    start      = 1'b0;
    result     = '0;
    error_in   = 1'b0;
    last_shown = BLANK5;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_digits", 64'(shown()), 64'(BLANK5));
    check("rst_busy",   64'(busy),    64'(0));
    check("rst_ready",  64'(ready),   64'(0));
    check("rst_sign",   64'(sign),    64'(0));
    check("rst_error",  64'(ERROR),   64'(0));
    rst = 1'b0;

    issue(16'd12345, 1'b0, segs5(1, 2, 3, 4, 5), 1'b0);
    wait_drain();
    issue(16'h8000,  1'b0, segs5(3, 2, 7, 6, 8), 1'b1);
    wait_drain();
    issue(16'd0,     1'b0, segs5(0, 0, 0, 0, 0), 1'b0);
    wait_drain();
    issue(-16'sd5,   1'b1, DASH5, 1'b0);
    wait_drain();

    // Second start during conversion is ignored; display holds meanwhile
    issue(16'd42, 1'b0, segs5(0, 0, 0, 4, 2), 1'b0);
    repeat (3) @(posedge clk);
    pulse(16'd99, 1'b0, acc);
    check("hold_during_convert", 64'(shown()), 64'(last_shown));
    check("busy_mid_convert",    64'(busy),    64'(1));
    wait_drain();

    issue(16'hFFFF,  1'b0, segs5(0, 0, 0, 0, 1), 1'b1);
    wait_drain();
    issue(16'd9999,  1'b0, segs5(0, 9, 9, 9, 9), 1'b0);
    wait_drain();
    issue(16'd32767, 1'b0, segs5(3, 2, 7, 6, 7), 1'b0);
    wait_drain();

    // A start sampled while in LOAD is dropped; a reissue is accepted
    issue(16'd100, 1'b0, segs5(0, 0, 1, 0, 0), 1'b0);
    repeat (16) @(posedge clk);
    pulse(16'd555, 1'b0, acc);
    check("idle_after_load_start", 64'(busy), 64'(0));
    issue(16'd555, 1'b0, segs5(0, 0, 5, 5, 5), 1'b0);
    wait_drain();

    // Reset mid-conversion blanks immediately and suppresses ready
    pulse(16'd777, 1'b0, acc);
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midrst_digits", 64'(shown()), 64'(BLANK5));
    check("midrst_busy",   64'(busy),    64'(0));
    check("midrst_sign",   64'(sign),    64'(0));
    last_shown = BLANK5;
    @(negedge clk);
    rst = 1'b0;
    repeat (25) @(posedge clk);
    check("scoreboard_empty", 64'(sb.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
